// File: rtl/nv_nvdla_cacc_psum_buf.sv
// Partial-sum assembly buffer for one int8 CACC calc lane: stores 34-bit partial
// sums, feeds them to the calc as in_op and writes the returned partials back.
module nv_nvdla_cacc_psum_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          mac_valid,
  input  logic [21:0]   mac_data,
  input  logic [AW-1:0] mac_addr,
  input  logic          mac_first,
  input  logic          mac_last,
  output logic          calc_in_valid,
  output logic [21:0]   calc_in_data,
  output logic [33:0]   calc_in_op,
  output logic          calc_in_op_valid,
  output logic          calc_in_sel,
  input  logic          calc_out_partial_valid,
  input  logic [33:0]   calc_out_partial_data,
  output logic          hazard_err,
  output logic          wb_err
);

  logic [33:0]   mem [DEPTH];
  logic [AW-1:0] s1_addr, s2_addr, s3_addr;
  logic          s2_valid, s2_last, s3_valid, s3_last;
  logic          wb_hit, wb_drop, rd_en, hazard;
  logic [33:0]   rd_data;

  // Calc returns the partial while its beat sits in S3; only non-last beats own a writeback.
  assign wb_hit  = calc_out_partial_valid & s3_valid & ~s3_last;
  assign wb_drop = calc_out_partial_valid & ~(s3_valid & ~s3_last);
  assign rd_en   = mac_valid & ~mac_first;

  // Write-first bypass: a read racing the S3 writeback to the same entry sees the new value,
  // which is what makes reuse at distance 3 legal.
  assign rd_data = (wb_hit && (s3_addr == mac_addr)) ? calc_out_partial_data : mem[mac_addr];

  // Entries still in S1/S2 have not been written back yet, so a read now would be stale.
  assign hazard = rd_en &
                  ((calc_in_valid & ~calc_in_sel & (s1_addr == mac_addr)) |
                   (s2_valid & ~s2_last & (s2_addr == mac_addr)));

  // NOTE: the storage array has no reset so it maps onto plain RAM; entries are
  // re-initialised functionally by a mac_first beat instead.
  always_ff @(posedge nvdla_core_clk) begin
    if (wb_hit) mem[s3_addr] <= calc_out_partial_data;
  end

  // NOTE: all state uses non-blocking assignments so every stage samples the
  // previous-cycle value of its neighbour regardless of statement order.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      calc_in_valid    <= 1'b0;
      calc_in_data     <= '0;
      calc_in_op       <= '0;
      calc_in_op_valid <= 1'b0;
      calc_in_sel      <= 1'b0;
      s1_addr          <= '0;
      s2_valid         <= 1'b0;
      s2_addr          <= '0;
      s2_last          <= 1'b0;
      s3_valid         <= 1'b0;
      s3_addr          <= '0;
      s3_last          <= 1'b0;
      hazard_err       <= 1'b0;
      wb_err           <= 1'b0;
    end else begin
      calc_in_valid    <= mac_valid;
      calc_in_data     <= mac_valid ? mac_data : '0;
      calc_in_sel      <= mac_valid & mac_last;
      calc_in_op_valid <= rd_en;
      calc_in_op       <= rd_en ? rd_data : '0;
      s1_addr          <= mac_addr;

      s2_valid         <= calc_in_valid;
      s2_addr          <= s1_addr;
      s2_last          <= calc_in_sel;

      s3_valid         <= s2_valid;
      s3_addr          <= s2_addr;
      s3_last          <= s2_last;

      if (hazard)  hazard_err <= 1'b1;
      if (wb_drop) wb_err     <= 1'b1;
    end
  end

  addr_in_range: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    mac_valid |-> (32'(mac_addr) < DEPTH));

endmodule

// File: tb/tb_nv_nvdla_cacc_psum_buf.sv
// Self-checking bench for nv_nvdla_cacc_psum_buf: behavioural entry/writeback model
// plus a 2-cycle calc model (partial = sext(data) + op) closing the loop.
module tb_nv_nvdla_cacc_psum_buf;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          nvdla_core_clk = 1'b0;
  logic          nvdla_core_rstn = 1'b0;
  logic          mac_valid = 1'b0;
  logic [21:0]   mac_data = '0;
  logic [AW-1:0] mac_addr = '0;
  logic          mac_first = 1'b0;
  logic          mac_last = 1'b0;
  logic          calc_in_valid;
  logic [21:0]   calc_in_data;
  logic [33:0]   calc_in_op;
  logic          calc_in_op_valid;
  logic          calc_in_sel;
  logic          calc_out_partial_valid = 1'b0;
  logic [33:0]   calc_out_partial_data = '0;
  logic          hazard_err;
  logic          wb_err;

  nv_nvdla_cacc_psum_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .nvdla_core_clk         (nvdla_core_clk),
    .nvdla_core_rstn        (nvdla_core_rstn),
    .mac_valid              (mac_valid),
    .mac_data               (mac_data),
    .mac_addr               (mac_addr),
    .mac_first              (mac_first),
    .mac_last               (mac_last),
    .calc_in_valid          (calc_in_valid),
    .calc_in_data           (calc_in_data),
    .calc_in_op             (calc_in_op),
    .calc_in_op_valid       (calc_in_op_valid),
    .calc_in_sel            (calc_in_sel),
    .calc_out_partial_valid (calc_out_partial_valid),
    .calc_out_partial_data  (calc_out_partial_data),
    .hazard_err             (hazard_err),
    .wb_err                 (wb_err)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  // Reference model: entry contents, which entries hold a defined value, and
  // writebacks still owed by in-flight non-last beats (due = edge they land on).
  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [33:0]   val;
  } wr_t;

  wr_t         pend[$];
  logic [33:0] ref_mem [DEPTH];
  bit          known [DEPTH];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        e_valid, e_sel, e_opv, e_hz, e_wb;
  logic [21:0] e_data;
  logic [33:0] e_op;
  logic        c1_v, c2_v;
  logic [33:0] c1_d, c2_d;

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    pend.delete();
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    {e_valid, e_sel, e_opv, e_hz, e_wb} = '0;
    e_data = '0;
    e_op   = '0;
    {c1_v, c2_v} = '0;
    c1_d = '0;
    c2_d = '0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "calc_in_valid"},    34'(calc_in_valid),    34'(e_valid));
    check({pfx, "calc_in_data"},     34'(calc_in_data),     34'(e_data));
    check({pfx, "calc_in_sel"},      34'(calc_in_sel),      34'(e_sel));
    check({pfx, "calc_in_op_valid"}, 34'(calc_in_op_valid), 34'(e_opv));
    check({pfx, "calc_in_op"},       calc_in_op,            e_op);
    check({pfx, "hazard_err"},       34'(hazard_err),       34'(e_hz));
    check({pfx, "wb_err"},           34'(wb_err),           34'(e_wb));
  endtask

  // One clock: called at the falling edge before the edge numbered cyc.
  task automatic step(input bit v, input logic [AW-1:0] a, input logic [21:0] d,
                      input bit f, input bit l, input bit inj);
    bit due_now;
    check_outputs("");

    due_now = 1'b0;
    foreach (pend[i]) if (pend[i].due == cyc) due_now = 1'b1;

    // Calc model: result appears two cycles after the operand beat is visible.
    calc_out_partial_valid = c2_v;
    calc_out_partial_data  = c2_d;
    c2_v = c1_v;
    c2_d = c1_d;
    c1_v = calc_in_valid & ~calc_in_sel;
    c1_d = {{12{calc_in_data[21]}}, calc_in_data} + calc_in_op;
    if (inj && !due_now) begin
      calc_out_partial_valid = 1'b1;
      calc_out_partial_data  = {2'($urandom), 32'($urandom)};
      e_wb = 1'b1;
    end

    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due <= cyc) begin
        ref_mem[pend[i].addr] = pend[i].val;
        known[pend[i].addr]   = 1'b1;
        pend.delete(i);
      end
    end

    if (v && !f && !known[a]) f = 1'b1;
    if (v && !f) foreach (pend[i]) if (pend[i].addr == a) e_hz = 1'b1;

    e_valid = v;
    e_data  = v ? d : '0;
    e_sel   = v & l;
    e_opv   = v & ~f;
    e_op    = e_opv ? ref_mem[a] : '0;
    if (v && !l) pend.push_back('{cyc + 3, a, {{12{d[21]}}, d} + e_op});

    mac_valid = v;
    mac_addr  = a;
    mac_data  = d;
    mac_first = f;
    mac_last  = l;
    @(posedge nvdla_core_clk);
    cyc++;
    @(negedge nvdla_core_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    nvdla_core_rstn        = 1'b0;
    calc_out_partial_valid = 1'b0;
    calc_out_partial_data  = '0;
    clear_model();
    #1;
    check_outputs("rst_");
    repeat (n) begin
      mac_valid = 1'b1;
      mac_addr  = AW'($urandom);
      mac_data  = 22'($urandom);
      mac_first = 1'b0;
      mac_last  = 1'b0;
      @(posedge nvdla_core_clk);
      cyc++;
      @(negedge nvdla_core_clk);
      check_outputs("rst_");
    end
    mac_valid       = 1'b0;
    nvdla_core_rstn = 1'b1;
  endtask

  initial begin
    clear_model();
    @(negedge nvdla_core_clk);
    do_reset(3);

    // First pass then accumulate on entry 3; final read shows 100 - 30 = 70.
    step(1'b1, 5'd3, 22'd100, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 5'd3, 22'h3FFFE2, 1'b0, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 5'd3, 22'd1, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Reuse at distance 3 via bypass; entry 7 ends at 11.
    step(1'b1, 5'd7, 22'd5, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 5'd7, 22'd6, 1'b0, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 5'd7, 22'd0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Reuse at distance 2: hazard, stale operand.
    step(1'b1, 5'd2, 22'd9, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 5'd2, 22'd1, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 5'd2, 22'd2, 1'b0, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 5'd2, 22'd0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Final pass on entry 4 plus a stray writeback: dropped, wb_err set.
    step(1'b1, 5'd4, 22'd44, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 5'd4, 22'd3, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 5'd4, 22'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd5, 22'd7, 1'b1, 1'b1, 1'b0);
    idle(3);

    do_reset(2);

    // Full-throughput first pass over every entry, then randomized traffic.
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), 22'($urandom), 1'b1, 1'b0, 1'b0);
    idle(4);
    repeat (400)
      step(($urandom % 4) != 0, AW'($urandom), 22'($urandom),
           ($urandom % 5) == 0, ($urandom % 5) == 0, ($urandom % 12) == 0);
    idle(4);

    // Final-pass stream interrupted by reset; entry 0 restarts cleanly afterwards.
    for (int i = 0; i < 16; i++) step(1'b1, AW'(i), 22'($urandom), 1'b0, 1'b1, 1'b0);
    do_reset(3);
    step(1'b1, 5'd0, 22'd123, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 5'd0, 22'd1, 1'b0, 1'b1, 1'b0);
    for (int i = 16; i < DEPTH; i++) step(1'b1, AW'(i), 22'($urandom), 1'b0, 1'b1, 1'b0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
